// File: rtl/spike_mon_pkg.sv
// Shared types and width helpers for the spike activity monitor.
// Imported by the popcount and the monitor top.
package spike_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CONVERGED
    } state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int acc_w(input int n, input int wlog2);
        return $clog2(n * (2 ** wlog2) + 1);
    endfunction

endpackage

// File: rtl/spike_popcount.sv
// Combinational population count of the spike bus.
// Shared by the instantaneous and window paths.
module spike_popcount
    import spike_mon_pkg::*;
#(
    parameter int N = 7,
    parameter int W = cnt_w(N)
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/spike_activity_monitor.sv
// Activity and convergence monitor for the Hopfield spike bus:
// windowed spike totals with a threshold flag, plus a stable-pattern detector.
module spike_activity_monitor
    import spike_mon_pkg::*;
#(
    parameter int N_NEURONS     = 7,
    parameter int WINDOW_LOG2   = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = cnt_w(N_NEURONS),
    parameter int ACC_W         = acc_w(N_NEURONS, WINDOW_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [N_NEURONS-1:0] spikes,
    input  logic [ACC_W-1:0]     thr,
    output logic [CNT_W-1:0]     inst_count,
    output logic [ACC_W-1:0]     win_count,
    output logic                 win_valid,
    output logic                 over_thr,
    output logic                 converged,
    output logic [N_NEURONS-1:0] conv_pattern
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0]       pop;
    logic [ACC_W-1:0]       sum;
    logic [CNT_W-1:0]       inst_q;
    logic [ACC_W-1:0]       acc_q, acc_d, win_q, win_d;
    logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
    logic                   valid_q, valid_d;
    logic                   over_q, over_d;
    logic                   conv_q, conv_d;
    logic [N_NEURONS-1:0]   prev_q, prev_d, pat_q, pat_d;
    logic [SW-1:0]          stab_q, stab_d;
    state_e                 state_q, state_d;

    spike_popcount #(
        .N (N_NEURONS),
        .W (CNT_W)
    ) u_pop (
        .bits_i  (spikes),
        .count_o (pop)
    );

    assign sum = acc_q + ACC_W'(pop);

    always_comb begin
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        win_d   = win_q;
        over_d  = over_q;
        valid_d = 1'b0;
        if (clear) begin
            acc_d  = '0;
            wcnt_d = '0;
            win_d  = '0;
            over_d = 1'b0;
        end else if (enable) begin
            if (&wcnt_q) begin
                win_d   = sum;
                over_d  = (sum >= thr);
                valid_d = 1'b1;
                acc_d   = '0;
                wcnt_d  = '0;
            end else begin
                acc_d  = sum;
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        stab_d  = stab_q;
        pat_d   = pat_q;
        conv_d  = conv_q;
        if (clear) begin
            state_d = IDLE;
            prev_d  = '0;
            stab_d  = '0;
            pat_d   = '0;
            conv_d  = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
            conv_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    prev_d  = spikes;
                    stab_d  = '0;
                end
                TRACK: begin
                    // An all-zero bus never counts toward convergence.
                    if (spikes != prev_q) begin
                        prev_d = spikes;
                        stab_d = '0;
                    end else if (spikes == '0) begin
                        stab_d = '0;
                    end else if (stab_q == STAB_LAST) begin
                        state_d = CONVERGED;
                        pat_d   = prev_q;
                        conv_d  = 1'b1;
                        stab_d  = '0;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
                CONVERGED: begin
                    if (spikes != pat_q) begin
                        state_d = TRACK;
                        conv_d  = 1'b0;
                        prev_d  = spikes;
                        stab_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            conv_q  <= 1'b0;
            prev_q  <= '0;
            pat_q   <= '0;
            stab_q  <= '0;
            state_q <= IDLE;
        end else begin
            inst_q  <= pop;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            over_q  <= over_d;
            conv_q  <= conv_d;
            prev_q  <= prev_d;
            pat_q   <= pat_d;
            stab_q  <= stab_d;
            state_q <= state_d;
        end
    end

    assign inst_count   = inst_q;
    assign win_count    = win_q;
    assign win_valid    = valid_q;
    assign over_thr     = over_q;
    assign converged    = conv_q;
    assign conv_pattern = pat_q;

endmodule

// File: tb/tb_spike_activity_monitor.sv
// Bench for spike_activity_monitor: run-length/window-sum model checked
// every cycle, plus hand-computed literal expectations.
module tb_spike_activity_monitor;

    localparam int N    = 7;
    localparam int WL   = 4;
    localparam int STAB = 8;
    localparam int WLEN = 2 ** WL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] spikes = '0;
    logic [6:0] thr = 7'd112;
    logic [2:0] inst_count;
    logic [6:0] win_count;
    logic       win_valid;
    logic       over_thr;
    logic       converged;
    logic [6:0] conv_pattern;

    int n_chk  = 0;
    int n_pass = 0;

    spike_activity_monitor #(
        .N_NEURONS     (N),
        .WINDOW_LOG2   (WL),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .spikes       (spikes),
        .thr          (thr),
        .inst_count   (inst_count),
        .win_count    (win_count),
        .win_valid    (win_valid),
        .over_thr     (over_thr),
        .converged    (converged),
        .conv_pattern (conv_pattern)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: window sum over enabled samples; converged when the last
    // STAB+1 enabled samples form one unbroken run of the same nonzero value.
    int         m_inst = 0, m_win = 0, m_sum = 0, m_cnt = 0, m_run = 0;
    logic       m_valid = 0, m_over = 0, m_conv = 0;
    logic [6:0] m_pat = '0, m_last = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inst = 0; m_win = 0; m_sum = 0; m_cnt = 0; m_run = 0;
            m_valid = 0; m_over = 0; m_conv = 0; m_pat = '0; m_last = '0;
        end else begin
            m_inst  = $countones(spikes);
            m_valid = 0;
            if (clear) begin
                m_sum = 0; m_cnt = 0; m_win = 0; m_over = 0;
                m_run = 0; m_conv = 0; m_pat = '0;
            end else if (enable) begin
                m_sum += m_inst;
                m_cnt++;
                if (m_cnt == WLEN) begin
                    m_win   = m_sum;
                    m_over  = (m_sum >= int'(thr));
                    m_valid = 1;
                    m_sum   = 0;
                    m_cnt   = 0;
                end
                if (m_run > 0 && spikes == m_last) m_run++;
                else m_run = 1;
                m_last = spikes;
                m_conv = (spikes != 0) && (m_run >= STAB + 1);
                if (m_conv) m_pat = spikes;
            end else begin
                m_run  = 0;
                m_conv = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("inst_count", int'(inst_count), m_inst);
        chk("win_count", int'(win_count), m_win);
        chk("win_valid", int'(win_valid), int'(m_valid));
        chk("over_thr", int'(over_thr), int'(m_over));
        chk("converged", int'(converged), int'(m_conv));
        chk("conv_pattern", int'(conv_pattern), int'(m_pat));
    end

    task automatic cyc(input logic en, input logic clr, input logic [6:0] sp);
        enable = en;
        clear  = clr;
        spikes = sp;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int rise;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-window with acc = 50
        repeat (7) cyc(1, 0, 7'h7F);
        cyc(1, 0, 7'h01);
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("rst_inst", int'(inst_count), 0);
        chk("rst_win", int'(win_count), 0);
        chk("rst_valid", int'(win_valid), 0);
        chk("rst_conv", int'(converged), 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1, 0, 7'h00);
            cnt += int'(win_valid);
        end
        chk("rst_no_early_valid", cnt, 0);
        cyc(1, 0, 7'h00);
        chk("rst_window_end", int'(win_valid), 1);

        // Full window of all-ones, thr 112 then 113
        thr = 7'd112;
        repeat (15) cyc(1, 0, 7'h7F);
        chk("ones_valid15", int'(win_valid), 0);
        cyc(1, 0, 7'h7F);
        chk("ones_valid16", int'(win_valid), 1);
        chk("ones_win", int'(win_count), 112);
        chk("ones_over112", int'(over_thr), 1);
        chk("ones_inst", int'(inst_count), 7);
        thr = 7'd113;
        repeat (16) cyc(1, 0, 7'h7F);
        chk("ones_win2", int'(win_count), 112);
        chk("ones_over113", int'(over_thr), 0);

        // Alternating 01/03 with a 5-cycle enable gap
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 7'h01);
            cyc(1, 0, 7'h03);
        end
        repeat (5) cyc(0, 0, 7'h7F);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 7'h01);
            cyc(1, 0, 7'h03);
        end
        chk("alt_valid", int'(win_valid), 1);
        chk("alt_win", int'(win_count), 24);

        // Constant pattern converges on edge 9
        cyc(0, 0, 7'h00);
        rise = 0;
        for (int e = 1; e <= 12; e++) begin
            cyc(1, 0, 7'h2D);
            if (converged && rise == 0) rise = e;
        end
        chk("conv_rise_edge", rise, 9);
        chk("conv_pat", int'(conv_pattern), 'h2D);

        // Disable drops converged, pattern held; one glitch restarts count
        cyc(0, 0, 7'h2D);
        chk("dis_conv", int'(converged), 0);
        chk("dis_pat_held", int'(conv_pattern), 'h2D);
        rise = 0;
        for (int e = 1; e <= 20; e++) begin
            cyc(1, 0, (e == 8) ? 7'h2C : 7'h2D);
            if (converged && rise == 0) rise = e;
        end
        chk("glitch_rise_edge", rise, 17);

        // Quiescent network never converges
        thr = 7'd100;
        cyc(1, 1, 7'h00);
        chk("clr_pat", int'(conv_pattern), 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 7'h00);
            cnt += int'(converged);
        end
        chk("quiet_conv", cnt, 0);

        // Clear landing on a window-end cycle drops the window
        cyc(1, 1, 7'h00);
        repeat (16) cyc(1, 0, 7'h7F);
        chk("pre_clr_win", int'(win_count), 112);
        chk("pre_clr_over", int'(over_thr), 1);
        repeat (15) cyc(1, 0, 7'h7F);
        cyc(1, 1, 7'h7F);
        chk("clr_end_valid", int'(win_valid), 0);
        chk("clr_end_win", int'(win_count), 0);
        chk("clr_end_over", int'(over_thr), 0);
        chk("clr_end_conv", int'(converged), 0);
        chk("clr_inst_live", int'(inst_count), 7);
        repeat (3) cyc(1, 0, 7'h05);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
